// File: rtl/ifetch_if.sv
// Fetch-side bus bundle: branch redirect, instruction-memory request/response and decode handoff.
interface ifetch_if;
  logic        bmu_vld;
  logic        ifetch_taken;
  logic [63:0] ifetch_taken_pc;
  logic        imem_req_vld;
  logic        imem_req_rdy;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_vld;
  logic [31:0] imem_rsp_data;
  logic        inst_vld;
  logic        inst_rdy;
  logic [31:0] inst;
  logic [63:0] inst_pc;

  // Fetch controller view.
  modport master (
    input  bmu_vld, ifetch_taken, ifetch_taken_pc,
    input  imem_req_rdy, imem_rsp_vld, imem_rsp_data, inst_rdy,
    output imem_req_vld, imem_req_addr, inst_vld, inst, inst_pc
  );

  // Environment view: branch unit, instruction memory and decode.
  modport slave (
    output bmu_vld, ifetch_taken, ifetch_taken_pc,
    output imem_req_rdy, imem_rsp_vld, imem_rsp_data, inst_rdy,
    input  imem_req_vld, imem_req_addr, inst_vld, inst, inst_pc
  );
endinterface

// File: rtl/ifetch_ctrl.sv
// Single-outstanding instruction fetch controller with branch redirect and
// stale-response dropping.
module ifetch_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic     clk,
  input  logic     rst_n,
  ifetch_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_t;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic        drop_q, drop_d;
  logic [31:0] inst_q, inst_d;
  logic [63:0] inst_pc_q, inst_pc_d;
  logic        redirect;

  assign redirect = bus.bmu_vld & bus.ifetch_taken;

  // State register.
  // NOTE: sequential state uses non-blocking assignments only; the held
  // instruction and its pc are reset too so IDLE drives all-zero outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      drop_q    <= 1'b0;
      inst_q    <= '0;
      inst_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      drop_q    <= drop_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
    end
  end

  // Next-state logic.
  // NOTE: every variable gets a hold default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    drop_d    = drop_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    case (state_q)
      IDLE: begin
        state_d = REQ;
        if (redirect) pc_d = bus.ifetch_taken_pc;
      end
      REQ: begin
        if (redirect) pc_d = bus.ifetch_taken_pc;
        // An accepted request carrying the pre-redirect address must be dropped.
        if (bus.imem_req_rdy) begin
          state_d = WAIT;
          drop_d  = redirect;
        end
      end
      WAIT: begin
        if (bus.imem_rsp_vld) begin
          if (drop_q || redirect) begin
            drop_d  = 1'b0;
            state_d = REQ;
            if (redirect) pc_d = bus.ifetch_taken_pc;
          end else begin
            inst_d    = bus.imem_rsp_data;
            inst_pc_d = pc_q;
            state_d   = OUT;
          end
        end else if (redirect) begin
          pc_d   = bus.ifetch_taken_pc;
          drop_d = 1'b1;
        end
      end
      OUT: begin
        // Redirect wins over a same-cycle handshake; decode flushes that word.
        if (redirect) begin
          pc_d    = bus.ifetch_taken_pc;
          state_d = REQ;
        end else if (bus.inst_rdy) begin
          pc_d    = pc_q + 64'd4;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode only registered state, never a live input.
  always_comb begin
    bus.imem_req_vld  = (state_q == REQ);
    bus.imem_req_addr = (state_q == REQ) ? pc_q : '0;
    bus.inst_vld      = (state_q == OUT);
    bus.inst          = inst_q;
    bus.inst_pc       = inst_pc_q;
  end

endmodule
